nvram_upload_responder: RTL

//  Serves HPS save-file upload reads (ioctl upload direction) from the game's battery/high-score
//  RAM, which the core otherwise writes. Arbitrates one read per ioctl_rd on a shared RAM port,

---
 rtl/nvram_upload_responder_pkg.sv | 25 ++
 rtl/nvram_upload_responder_if.sv | 38 +++
 rtl/nvram_upload_responder_quiet_timer.sv | 54 +++++
 rtl/nvram_upload_responder.sv | 103 ++++++++++
 4 files changed

// File: rtl/nvram_upload_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nvram_upload_pkg
// Purpose  : Shared constants for the NVRAM upload responder: FSM encodings,
//            out-of-range read data and reset value of the HPS data bus.
// Revision : 1.0 - initial release
// ============================================================================
package nvram_upload_pkg;

  // FSM encoding (IDLE / REQ / LAT), explicit 2-bit width
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_LAT  = 2'd2;

  // Byte returned for reads beyond the saved region
  localparam logic [7:0] OOR_DATA  = 8'hFF;
  // Value of ioctl_din out of reset
  localparam logic [7:0] RESET_DIN = 8'h00;

  // Width of the HPS ioctl byte address
  localparam int IOCTL_ADDR_W = 25;

endpackage
`default_nettype wire

// File: rtl/nvram_upload_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : nvram_upload_responder_if
// Purpose  : Bundles the HPS ioctl upload signals, the shared RAM read port
//            and the CPU write strobe seen by the upload responder.
// Revision : 1.0 - initial release
// ============================================================================
interface nvram_upload_responder_if #(
  parameter int ADDR_W = 10
) ();
  // HPS side
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              upload_req;
  // Shared RAM read port
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_q;
  // CPU write strobe into the saved region
  logic              cpu_wr;

  // Responder view
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_gnt, mem_q, cpu_wr,
    output ioctl_din, ioctl_wait, upload_req, mem_req, mem_addr
  );

  // Environment view (HPS, arbiter/RAM, CPU)
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_gnt, mem_q, cpu_wr,
    input  ioctl_din, ioctl_wait, upload_req, mem_req, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/nvram_upload_responder_quiet_timer.sv
`default_nettype none
// ============================================================================
// Module   : nvram_quiet_timer
// Purpose  : Tracks CPU writes to the saved region and pulses upload_req once
//            the region has been quiet for QUIET_CYCLES clocks. The countdown
//            is frozen while an upload session is active.
// Revision : 1.0 - initial release
// ============================================================================
module nvram_quiet_timer #(
  parameter int QUIET_CYCLES = 4000000
) (
  input  wire logic clk_sys,
  input  wire logic reset_n,
  input  wire logic cpu_wr_i,
  input  wire logic freeze_i,
  output logic      upload_req_o
);
  localparam int                CNT_W    = $clog2(QUIET_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(QUIET_CYCLES - 1);

  logic             dirty_q, dirty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A write always wins over expiry; otherwise count down (saturating) or fire
  always_comb begin
    dirty_d      = dirty_q;
    cnt_d        = cnt_q;
    upload_req_o = 1'b0;
    if (cpu_wr_i) begin
      dirty_d = 1'b1;
      cnt_d   = CNT_LOAD;
    end else if (dirty_q && !freeze_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        upload_req_o = 1'b1;
        dirty_d      = 1'b0;
      end
    end
  end

  // Dirty flag and quiet counter registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nvram_upload_responder.sv
`default_nettype none
// ============================================================================
// Module   : nvram_upload_responder
// Purpose  : Serves HPS save-file upload reads from the battery/high-score RAM
//            through a shared, arbitrated read port, stalling the HPS with
//            ioctl_wait, and requests an auto-save after CPU writes go quiet.
// Revision : 1.0 - initial release
// ============================================================================
module nvram_upload_responder
  import nvram_upload_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int RAM_LATENCY  = 1,
  parameter int QUIET_CYCLES = 4000000
) (
  input  wire logic               clk_sys,
  input  wire logic               reset_n,
  nvram_upload_responder_if.slave bus
);
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        din_q, din_d;
  logic [1:0]        lat_q, lat_d;
  logic              in_range;

  // Upper address bits beyond the region must all be zero
  assign in_range = (bus.ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);

  // Read FSM: accept one strobe in IDLE, hold request until granted, wait out RAM latency
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    lat_d      = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ioctl_rd && bus.ioctl_upload) begin
          if (in_range) begin
            mem_addr_d = bus.ioctl_addr[ADDR_W-1:0];
            state_d    = ST_REQ;
          end else begin
            din_d = OOR_DATA;
          end
        end
      end
      ST_REQ: begin
        if (!bus.ioctl_upload) begin
          state_d = ST_IDLE;
        end else if (bus.mem_gnt) begin
          lat_d   = LAT_LOAD;
          state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        if (!bus.ioctl_upload) begin
          state_d = ST_IDLE;
        end else if (lat_q == 2'd0) begin
          din_d   = bus.mem_q;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; reset abandons any read in flight
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      din_q      <= RESET_DIN;
      lat_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      lat_q      <= lat_d;
    end
  end

  // Request is dropped in the abort cycle so the arbiter never grants a dead read
  assign bus.mem_req    = (state_q == ST_REQ) && bus.ioctl_upload;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.ioctl_din  = din_q;
  // Wait covers the strobe cycle itself, before the FSM has left IDLE
  assign bus.ioctl_wait = bus.ioctl_rd || (state_q != ST_IDLE);

  nvram_quiet_timer #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet_timer (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cpu_wr_i     (bus.cpu_wr),
    .freeze_i     (bus.ioctl_upload),
    .upload_req_o (bus.upload_req)
  );

endmodule
`default_nettype wire
